// File: rtl/pfpu_rsqrt_pkg.sv
// Shared types, constants and float helpers for the PFPU reciprocal square root ALU.
// Holds the Newton-step "1.5 - t" fixed-point helper and the special-operand classifier.
package pfpu_rsqrt_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam int FP_W   = 1 + EXP_W + MANT_W;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, SUB, MUL3, OUT} state_e;

  typedef enum logic [1:0] {SP_NONE, SP_INF, SP_ZERO, SP_NAN} sp_class_e;

  localparam logic [24:0]     ONE_POINT_FIVE_Q24 = 25'h1800000;
  localparam logic [FP_W-1:0] FP_ONE             = 32'h3f800000;
  localparam logic [FP_W-1:0] FP_INF             = 32'h7f800000;
  localparam logic [FP_W-1:0] FP_QNAN            = 32'h7fc00000;

  // t is x*y*y/2, expected near 0.5; outside [0.25,1) the step is skipped by returning 1.0.
  function automatic fp32_t nr_sub(input fp32_t t);
    logic [24:0] v;
    logic [24:0] d;
    fp32_t       res;
    v   = '0;
    d   = '0;
    res = FP_ONE;
    if (t.expo == 8'd126 || t.expo == 8'd125) begin
      v = (t.expo == 8'd126) ? {2'b01, t.mant} : ({2'b01, t.mant} >> 1);
      d = ONE_POINT_FIVE_Q24 - v;
      res.sign = 1'b0;
      if (d[24]) begin
        res.expo = 8'd127;
        res.mant = d[23:1];
      end else begin
        res.expo = 8'd126;
        res.mant = d[22:0];
      end
    end
    return res;
  endfunction

  function automatic sp_class_e classify(input fp32_t x);
    if (x.expo == '0) return SP_INF;
    if (x == FP_INF) return SP_ZERO;
    if (x.sign || (x.expo == '1 && x.mant != '0)) return SP_NAN;
    return SP_NONE;
  endfunction

endpackage

// File: rtl/pfpu_rsqrt_if.sv
// Operand/result bundle between the PFPU scheduler (master) and the rsqrt ALU (slave).
interface pfpu_rsqrt_if;
  import pfpu_rsqrt_pkg::*;

  logic [FP_W-1:0] a;
  logic            valid_i;
  logic [FP_W-1:0] r;
  logic            valid_o;
  logic            busy_o;
  logic            drop_o;

  modport master (output a, valid_i, input r, valid_o, busy_o, drop_o);
  modport slave  (input a, valid_i, output r, valid_o, busy_o, drop_o);
endinterface

// File: rtl/pfpu_rsqrt_fmul.sv
// Combinational single-precision multiply: truncated 24x24 significand product, flush to +/-0, saturate to +/-inf.
module pfpu_rsqrt_fmul
  import pfpu_rsqrt_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t p_o
);
  logic [47:0] prod;
  logic [9:0]  e_sum;
  logic        sign;
  logic        unused_lo;

  always_comb begin
    sign  = a_i.sign ^ b_i.sign;
    prod  = {24'b0, 1'b1, a_i.mant} * {24'b0, 1'b1, b_i.mant};
    // Two's complement in 10 bits: the sum spans -127..384, so bit 9 is the sign.
    e_sum = {2'b00, a_i.expo} + {2'b00, b_i.expo} - 10'(BIAS) + {9'b0, prod[47]};
    p_o   = '0;
    if (a_i.expo == '0 || b_i.expo == '0 || e_sum[9] || e_sum == '0) begin
      p_o.sign = sign;
    end else if (e_sum >= 10'd255) begin
      p_o.sign = sign;
      p_o.expo = '1;
    end else begin
      p_o.sign = sign;
      p_o.expo = e_sum[7:0];
      p_o.mant = prod[47] ? prod[46:24] : prod[45:23];
    end
  end

  assign unused_lo = ^prod[22:0];
endmodule

// File: rtl/pfpu_rsqrt.sv
// Iterative rsqrt: magic estimate then ITERATIONS Newton steps on one fmul, latency 2+4*ITERATIONS, busy until valid_o.
// No backpressure: valid_i while busy is discarded with drop_o; PFPU_RSQRT_SPECIAL_EN forces IEEE special results.
module pfpu_rsqrt
  import pfpu_rsqrt_pkg::*;
#(
  parameter int unsigned     ITERATIONS = 1,
  parameter logic [FP_W-1:0] MAGIC      = 32'h5f3759df
) (
  input  logic        sys_clk,
  input  logic        alu_rst,
  pfpu_rsqrt_if.slave io
);
  localparam logic [1:0] ITER_LAST = 2'(ITERATIONS - 1);

  state_e     state_q, state_d;
  fp32_t      y_q, y_d, h_q, h_d, t_q, t_d, r_q, r_d;
  logic [1:0] cnt_q, cnt_d;
  logic       valid_q;
  fp32_t      a_in, mul_a, mul_b, mul_p, res_val;
  logic       accept, busy;

  assign a_in   = io.a;
  // The cycle valid_o pulses still counts as busy, so the earliest re-issue is one cycle later.
  assign busy   = (state_q != IDLE) || valid_q;
  assign accept = (state_q == IDLE) && !valid_q && io.valid_i;

  pfpu_rsqrt_fmul u_fmul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    h_d     = h_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    mul_a   = y_q;
    mul_b   = y_q;
    case (state_q)
      IDLE: if (accept) begin
        y_d     = MAGIC - {2'b00, a_in[30:1]};
        h_d     = (a_in.expo == '0) ? '0 : {a_in.sign, a_in.expo - 8'd1, a_in.mant};
        cnt_d   = '0;
        state_d = (ITERATIONS == 0) ? OUT : MUL1;
      end
      MUL1: begin
        t_d     = mul_p;
        state_d = MUL2;
      end
      MUL2: begin
        mul_a   = h_q;
        mul_b   = t_q;
        t_d     = mul_p;
        state_d = SUB;
      end
      SUB: begin
        t_d     = nr_sub(t_q);
        state_d = MUL3;
      end
      MUL3: begin
        mul_b   = t_q;
        y_d     = mul_p;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == ITER_LAST) ? OUT : MUL1;
      end
      OUT: begin
        r_d     = res_val;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PFPU_RSQRT_SPECIAL_EN
  sp_class_e cls_q, cls_d;

  assign cls_d = accept ? classify(a_in) : cls_q;

  always_ff @(posedge sys_clk or posedge alu_rst) begin
    if (alu_rst) cls_q <= SP_NONE;
    else         cls_q <= cls_d;
  end

  always_comb begin
    res_val = y_q;
    case (cls_q)
      SP_INF:  res_val = FP_INF;
      SP_ZERO: res_val = '0;
      SP_NAN:  res_val = FP_QNAN;
      default: res_val = y_q;
    endcase
  end
`else
  assign res_val = y_q;
`endif

  always_ff @(posedge sys_clk or posedge alu_rst) begin
    if (alu_rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      h_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      h_q     <= h_d;
      t_q     <= t_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_q == OUT);
    end
  end

  assign io.r       = r_q;
  assign io.valid_o = valid_q;
  assign io.busy_o  = busy;
  assign io.drop_o  = io.valid_i && busy;
endmodule

// File: tb/tb_pfpu_rsqrt.sv
// Bench for pfpu_rsqrt at ITERATIONS 0, 1 and 2: cycle-level handshake model plus numeric accuracy checks.
module tb_pfpu_rsqrt;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pfpu_rsqrt_if if0 ();
  pfpu_rsqrt_if if1 ();
  pfpu_rsqrt_if if2 ();

  pfpu_rsqrt #(.ITERATIONS(0)) u0 (.sys_clk(clk), .alu_rst(rst), .io(if0.slave));
  pfpu_rsqrt #(.ITERATIONS(1)) u1 (.sys_clk(clk), .alu_rst(rst), .io(if1.slave));
  pfpu_rsqrt #(.ITERATIONS(2)) u2 (.sys_clk(clk), .alu_rst(rst), .io(if2.slave));

  bit          m_have [3];
  int          m_acc  [3];
  logic [31:0] m_a    [3];

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic int lat_of(input int k);
    return 2 + 4 * k;
  endfunction

  function automatic real tol_of(input int k);
    return (k == 1) ? 2.0e-3 : 1.0e-5;
  endfunction

  function automatic real f2r(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(v[22:0]) / 8388608.0;
    m = m * (2.0 ** real'(e - 127));
    return v[31] ? -m : m;
  endfunction

  function automatic real rel_err(input real got, input real want);
    real d;
    d = (got - want) / want;
    return (d < 0.0) ? -d : d;
  endfunction

  task automatic drive(input int k, input logic v, input logic [31:0] x);
    case (k)
      0: begin if0.valid_i = v; if0.a = x; end
      1: begin if1.valid_i = v; if1.a = x; end
      default: begin if2.valid_i = v; if2.a = x; end
    endcase
  endtask

  function automatic logic get_vo(input int k);
    case (k)
      0: return if0.valid_o;
      1: return if1.valid_o;
      default: return if2.valid_o;
    endcase
  endfunction

  function automatic logic [31:0] get_r(input int k);
    case (k)
      0: return if0.r;
      1: return if1.r;
      default: return if2.r;
    endcase
  endfunction

  task automatic check_result(input int k, input logic [31:0] x, input logic [31:0] r);
    logic [31:0] ex;
    real         want;
`ifdef PFPU_RSQRT_SPECIAL_EN
    ex = 32'h0;
    if (x[30:23] == 8'h00) ex = 32'h7f800000;
    else if (x == 32'h7f800000) ex = 32'h00000000;
    else if (x[31] || (x[30:23] == 8'hff && x[22:0] != 0)) ex = 32'h7fc00000;
    else ex = 32'hffffffff;
    if (ex != 32'hffffffff) begin
      chk(r == ex, $sformatf("special[%0d] a=%h got r=%h want %h", k, x, r, ex));
      return;
    end
`endif
    if (k == 0) begin
      ex = 32'h5f3759df - {2'b00, x[30:1]};
      chk(r == ex, $sformatf("estimate[%0d] a=%h got r=%h want %h", k, x, r, ex));
    end else begin
      want = 1.0 / $sqrt(f2r({1'b0, x[30:0]}));
      chk(rel_err(f2r(r), want) < tol_of(k),
          $sformatf("accuracy[%0d] a=%h got r=%h (%g) want %g within %g", k, x, r, f2r(r), want, tol_of(k)));
    end
  endtask

  // Spec-level handshake model: acceptance in cycle c means busy in c+1..c+L and valid_o in c+L.
  task automatic model_step(input int k, input logic vi, input logic [31:0] x, input logic vo,
                            input logic bo, input logic dr, input logic [31:0] r);
    bit eb, ev;
    if (rst) begin
      chk(!vo && !bo && !dr && r == 32'h0,
          $sformatf("reset_outs[%0d] cyc=%0d got vo=%b busy=%b drop=%b r=%h want all 0", k, cyc, vo, bo, dr, r));
      m_have[k] = 1'b0;
      return;
    end
    eb = m_have[k] && cyc > m_acc[k] && cyc <= m_acc[k] + lat_of(k);
    ev = m_have[k] && cyc == m_acc[k] + lat_of(k);
    chk(bo == eb, $sformatf("busy[%0d] cyc=%0d got %b want %b", k, cyc, bo, eb));
    chk(vo == ev, $sformatf("valid[%0d] cyc=%0d got %b want %b", k, cyc, vo, ev));
    chk(dr == (vi && eb), $sformatf("drop[%0d] cyc=%0d got %b want %b", k, cyc, dr, vi && eb));
    if (ev) begin
      check_result(k, m_a[k], r);
      m_have[k] = 1'b0;
    end
    if (vi && !eb) begin
      m_have[k] = 1'b1;
      m_acc[k]  = cyc;
      m_a[k]    = x;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, if0.valid_i, if0.a, if0.valid_o, if0.busy_o, if0.drop_o, if0.r);
    model_step(1, if1.valid_i, if1.a, if1.valid_o, if1.busy_o, if1.drop_o, if1.r);
    model_step(2, if2.valid_i, if2.a, if2.valid_o, if2.busy_o, if2.drop_o, if2.r);
  end

  task automatic run(input int k, input logic [31:0] x, output int lat, output logic [31:0] res);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    res  = 32'h0;
    @(posedge clk); #1;
    drive(k, 1'b1, x);
    @(posedge clk); #1;
    drive(k, 1'b0, 32'h0);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (get_vo(k)) begin
        seen = 1'b1;
        lat  = n;
        res  = get_r(k);
      end else begin
        @(posedge clk);
      end
    end
    chk(seen, $sformatf("timeout[%0d] a=%h got no valid_o want one within 40 cycles", k, x));
    @(posedge clk);
  endtask

  logic [31:0] vecs [7] = '{32'h40000000, 32'h3e800000, 32'h42c80000, 32'h41800000,
                            32'h3f333333, 32'h3a83126f, 32'h4640e400};

  initial begin
    int          lat, n;
    logic [31:0] res, got;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'h0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(if1.r == 0 && if1.busy_o == 0 && if1.valid_o == 0 && if1.drop_o == 0,
        $sformatf("reset_state got r=%h busy=%b valid=%b want 0", if1.r, if1.busy_o, if1.valid_o));
    rst = 1'b0;
    @(posedge clk);

    run(1, 32'h3f800000, lat, res);
    chk(lat == 6, $sformatf("lat_iter1 got %0d want 6", lat));
    chk(rel_err(f2r(res), 1.0) < 2.0e-3, $sformatf("rsqrt(1.0) got %h want 1.0 within 2e-3", res));

    run(0, 32'h40800000, lat, res);
    chk(lat == 2, $sformatf("lat_iter0 got %0d want 2", lat));
    chk(res == 32'h3ef759df, $sformatf("estimate(4.0) got %h want 3ef759df", res));

    run(2, 32'h41c80000, lat, res);
    chk(lat == 10, $sformatf("lat_iter2 got %0d want 10", lat));
    chk(rel_err(f2r(res), 0.2) < 1.0e-5, $sformatf("rsqrt(25.0) got %h want 0.2 within 1e-5", res));

    for (int k = 0; k < 3; k++) begin
      foreach (vecs[i]) begin
        run(k, vecs[i], lat, res);
        chk(lat == lat_of(k), $sformatf("lat[%0d] a=%h got %0d want %0d", k, vecs[i], lat, lat_of(k)));
      end
    end

    // Operand held for three cycles: only the first is taken.
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h3f800000);
    #2 chk(if1.drop_o == 1'b0, $sformatf("drop_c0 got %b want 0", if1.drop_o));
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h40000000);
    #2 chk(if1.drop_o == 1'b1, $sformatf("drop_c1 got %b want 1", if1.drop_o));
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h40800000);
    #2 chk(if1.drop_o == 1'b1, $sformatf("drop_c2 got %b want 1", if1.drop_o));
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h0);
    n   = 0;
    got = 32'h0;
    repeat (14) begin
      @(negedge clk);
      if (if1.valid_o) begin
        n++;
        got = if1.r;
      end
    end
    chk(n == 1, $sformatf("drop_valid_count got %0d want 1", n));
    chk(rel_err(f2r(got), 1.0) < 2.0e-3, $sformatf("drop_first_result got %h want 1.0 within 2e-3", got));

    // Abort in flight: r still holds the previous nonzero result before reset.
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h40800000);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk(if1.valid_o == 0 && if1.busy_o == 0 && if1.r == 0,
           $sformatf("midop_reset got valid=%b busy=%b r=%h want 0", if1.valid_o, if1.busy_o, if1.r));
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (if1.valid_o) n++;
    end
    chk(n == 0, $sformatf("aborted_valid_count got %0d want 0", n));
    run(1, 32'h3f800000, lat, res);
    chk(lat == 6, $sformatf("lat_after_reset got %0d want 6", lat));
    chk(rel_err(f2r(res), 1.0) < 2.0e-3, $sformatf("after_reset rsqrt(1.0) got %h want 1.0 within 2e-3", res));

`ifdef PFPU_RSQRT_SPECIAL_EN
    run(1, 32'h00000000, lat, res);
    chk(lat == 6 && res == 32'h7f800000, $sformatf("special_zero got lat=%0d r=%h want 6 7f800000", lat, res));
    run(1, 32'hbf800000, lat, res);
    chk(lat == 6 && res == 32'h7fc00000, $sformatf("special_neg got lat=%0d r=%h want 6 7fc00000", lat, res));
    run(1, 32'h7f800000, lat, res);
    chk(lat == 6 && res == 32'h00000000, $sformatf("special_inf got lat=%0d r=%h want 6 0", lat, res));
    run(0, 32'h00000000, lat, res);
    chk(lat == 2 && res == 32'h7f800000, $sformatf("special_zero_i0 got lat=%0d r=%h want 2 7f800000", lat, res));
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
